// File: rtl/syn_weight_updater.sv
// -----------------------------------------------------------------------------
// syn_weight_updater
//
// Purpose: read-modify-write engine for a synaptic weight SRAM. Each accepted
// request reads one SRAM word and adds or subtracts a step to the weights
// selected by the mask. It writes the word back and then pulses UPD_DONE. The
// SRAM is assumed to have a 1-cycle registered read: data for a read issued in
// READ is presented on SRAM_Q during WAIT.
//
// Configuration macro: SYN_WEIGHT_SAT_EN
//   defined   -> updated weights clamp to [0, 2^WEIGHT_WIDTH-1]
//   undefined -> updated weights wrap modulo 2^WEIGHT_WIDTH
//
// Ports:
//   CK          clock, rising edge
//   RST_N       asynchronous active-low reset
//   UPD_VALID   request valid
//   UPD_READY   block can accept a request (high only in IDLE)
//   UPD_ADDR    target word address
//   UPD_MASK    per-synapse update enable (NSYN bits)
//   UPD_DIR     1 = potentiate (add), 0 = depress (subtract)
//   UPD_STEP    unsigned step magnitude
//   UPD_DONE    one-cycle pulse per completed request
//   SRAM_CS     SRAM chip select
//   SRAM_WE     SRAM write enable (only ever high together with SRAM_CS)
//   SRAM_A      SRAM word address
//   SRAM_D      SRAM write data
//   SRAM_Q      SRAM read data
//   DBG_STATE   current FSM state (IDLE=0 READ=1 WAIT=2 WRITE=3 DONE=4)
//
// Handshake: a request transfers on a rising edge where UPD_VALID and
// UPD_READY are both high. UPD_READY is high only in IDLE, and request inputs
// are ignored in all other states. UPD_VALID may stay high across requests.
// In that case one request is taken for each cycle in which UPD_READY is high.
// -----------------------------------------------------------------------------
module syn_weight_updater #(
   parameter int ADDR_WIDTH   = 8,
   parameter int DATA_WIDTH   = 32,
   parameter int WEIGHT_WIDTH = 4
) (
   input  logic                               CK,
   input  logic                               RST_N,
   input  logic                               UPD_VALID,
   output logic                               UPD_READY,
   input  logic [ADDR_WIDTH-1:0]              UPD_ADDR,
   input  logic [DATA_WIDTH/WEIGHT_WIDTH-1:0] UPD_MASK,
   input  logic                               UPD_DIR,
   input  logic [WEIGHT_WIDTH-1:0]            UPD_STEP,
   output logic                               UPD_DONE,
   output logic                               SRAM_CS,
   output logic                               SRAM_WE,
   output logic [ADDR_WIDTH-1:0]              SRAM_A,
   output logic [DATA_WIDTH-1:0]              SRAM_D,
   input  logic [DATA_WIDTH-1:0]              SRAM_Q,
   output logic [2:0]                         DBG_STATE
);

   localparam int NSYN = DATA_WIDTH / WEIGHT_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_WAIT  = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                  state_q, state_d;
   logic                    ready_q, ready_d;
   logic                    done_q,  done_d;
   logic                    cs_q,    cs_d;
   logic                    we_q,    we_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [ADDR_WIDTH-1:0]   addr_q,  addr_d;
   logic [NSYN-1:0]         mask_q,  mask_d;
   logic                    dir_q,   dir_d;
   logic [WEIGHT_WIDTH-1:0] step_q,  step_d;

   logic                    accept;
   logic [DATA_WIDTH-1:0]   new_word;

   // One synapse update. The sum is taken one bit wider than a weight, so
   // bit WEIGHT_WIDTH flags an add overflow or a subtract borrow.
   function automatic logic [WEIGHT_WIDTH-1:0] upd_weight(
      input logic [WEIGHT_WIDTH-1:0] w,
      input logic [WEIGHT_WIDTH-1:0] s,
      input logic                    up
   );
      logic [WEIGHT_WIDTH:0] r;
      r = up ? ({1'b0, w} + {1'b0, s}) : ({1'b0, w} - {1'b0, s});
`ifdef SYN_WEIGHT_SAT_EN
      if (r[WEIGHT_WIDTH])
         upd_weight = up ? {WEIGHT_WIDTH{1'b1}} : {WEIGHT_WIDTH{1'b0}};
      else
         upd_weight = r[WEIGHT_WIDTH-1:0];
`else
      upd_weight = r[WEIGHT_WIDTH-1:0];
`endif
   endfunction

   // Updated word, built from SRAM_Q while it is valid (WAIT). Masked-off
   // synapses pass through untouched.
   always_comb begin
      new_word = SRAM_Q;
      for (int k = 0; k < NSYN; k++) begin
         if (mask_q[k])
            new_word[k*WEIGHT_WIDTH +: WEIGHT_WIDTH] =
               upd_weight(SRAM_Q[k*WEIGHT_WIDTH +: WEIGHT_WIDTH], step_q, dir_q);
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      mask_d  = mask_q;
      dir_d   = dir_q;
      step_d  = step_q;
      wdata_d = wdata_q;
      accept  = ready_q & UPD_VALID;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               addr_d  = UPD_ADDR;
               mask_d  = UPD_MASK;
               dir_d   = UPD_DIR;
               step_d  = UPD_STEP;
               // An empty mask changes nothing, so the SRAM is skipped.
               state_d = (UPD_MASK != '0) ? S_READ : S_DONE;
            end
         end
         S_READ:  state_d = S_WAIT;
         S_WAIT: begin
            wdata_d = new_word;
            state_d = S_WRITE;
         end
         S_WRITE: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so that they are registered
      // and line up exactly with the state they belong to.
      ready_d = (state_d == S_IDLE);
      done_d  = (state_d == S_DONE);
      cs_d    = (state_d == S_READ) || (state_d == S_WRITE);
      we_d    = (state_d == S_WRITE);
   end

   always_ff @(posedge CK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         ready_q <= 1'b0;
         done_q  <= 1'b0;
         cs_q    <= 1'b0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         addr_q  <= '0;
         mask_q  <= '0;
         dir_q   <= 1'b0;
         step_q  <= '0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         cs_q    <= cs_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         addr_q  <= addr_d;
         mask_q  <= mask_d;
         dir_q   <= dir_d;
         step_q  <= step_d;
      end
   end

   assign UPD_READY = ready_q;
   assign UPD_DONE  = done_q;
   assign SRAM_CS   = cs_q;
   assign SRAM_WE   = we_q;
   assign SRAM_A    = addr_q;
   assign SRAM_D    = wdata_q;
   assign DBG_STATE = state_q;

endmodule

// File: tb/tb_syn_weight_updater.sv
// -----------------------------------------------------------------------------
// Testbench for syn_weight_updater. A behavioural SRAM sits on the memory port.
// A transaction-level model predicts the outputs for each cycle and keeps a
// reference copy of the memory contents. Directed cases pin known words and
// latencies, and randomized traffic follows them.
// -----------------------------------------------------------------------------
module tb_syn_weight_updater;

   localparam int AW   = 8;
   localparam int DW   = 32;
   localparam int WW   = 4;
   localparam int NS   = DW / WW;
   localparam int WMAX = (1 << WW) - 1;

   // ---------------- clock / reset ----------------
   logic          CK = 1'b0;
   logic          RST_N = 1'b1;
   logic          UPD_VALID = 1'b0;
   logic [AW-1:0] UPD_ADDR = '0;
   logic [NS-1:0] UPD_MASK = '0;
   logic          UPD_DIR = 1'b0;
   logic [WW-1:0] UPD_STEP = '0;
   logic          UPD_READY, UPD_DONE, SRAM_CS, SRAM_WE;
   logic [AW-1:0] SRAM_A;
   logic [DW-1:0] SRAM_D;
   logic [DW-1:0] SRAM_Q;
   logic [2:0]    dbg_state;

   always #5 CK = ~CK;

   syn_weight_updater #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW)) dut (
      .CK(CK), .RST_N(RST_N),
      .UPD_VALID(UPD_VALID), .UPD_READY(UPD_READY), .UPD_ADDR(UPD_ADDR),
      .UPD_MASK(UPD_MASK), .UPD_DIR(UPD_DIR), .UPD_STEP(UPD_STEP),
      .UPD_DONE(UPD_DONE), .SRAM_CS(SRAM_CS), .SRAM_WE(SRAM_WE),
      .SRAM_A(SRAM_A), .SRAM_D(SRAM_D), .SRAM_Q(SRAM_Q), .DBG_STATE(dbg_state)
   );

   // ---------------- SRAM (1-cycle registered read) ----------------
   logic [DW-1:0] mem [0:255];
   logic [DW-1:0] sram_q_r = '0;
   logic          pre_en = 1'b0;
   logic [AW-1:0] pre_addr = '0;
   logic [DW-1:0] pre_data = '0;

   always @(posedge CK) begin
      if (pre_en)
         mem[pre_addr] <= pre_data;
      else if (SRAM_CS && SRAM_WE)
         mem[SRAM_A] <= SRAM_D;
      if (SRAM_CS && !SRAM_WE)
         sram_q_r <= mem[SRAM_A];
   end
   assign SRAM_Q = sram_q_r;

   // ---------------- reference model ----------------
   typedef struct packed {
      logic          ready;
      logic          done;
      logic          cs;
      logic          we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } exp_t;

   exp_t          exp_q[$];           // expected outputs of upcoming cycles
   exp_t          cur = '0;           // expected outputs of the current cycle
   logic [DW-1:0] ref_mem [0:255];
   int            cyc = 0;
   int            acc_cyc = -1;
   int            m_acc_count = 0;
   logic          m_accepted = 1'b0;

   // observations
   int            done_cyc = -1;
   int            done_count = 0;
   int            cs_count = 0;
   int            wr_count = 0;
   logic [DW-1:0] dut_wd = '0;
   logic [AW-1:0] dut_ra = '0;

   // ---------------- scoreboard counters ----------------
   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic exp_t mk(input logic r, input logic dn, input logic cs,
                               input logic we, input logic [AW-1:0] a,
                               input logic [DW-1:0] d);
      exp_t e;
      e.ready = r; e.done = dn; e.cs = cs; e.we = we; e.a = a; e.d = d;
      return e;
   endfunction

   // A request has been taken. Compute the word it must write from the
   // reference memory, then queue the cycle-by-cycle outputs it produces.
   task automatic model_accept();
      logic [DW-1:0] old_w, new_w;
      int w, s, r;
      m_accepted = 1'b1;
      acc_cyc    = cyc;
      m_acc_count++;
      old_w = ref_mem[UPD_ADDR];
      new_w = old_w;
      s     = int'(UPD_STEP);
      for (int k = 0; k < NS; k++) begin
         if (UPD_MASK[k]) begin
            w = int'(old_w[k*WW +: WW]);
            r = UPD_DIR ? (w + s) : (w - s);
`ifdef SYN_WEIGHT_SAT_EN
            if (r < 0) r = 0;
            if (r > WMAX) r = WMAX;
`else
            r = r & WMAX;
`endif
            new_w[k*WW +: WW] = r[WW-1:0];
         end
      end
      if (UPD_MASK != '0) begin
         exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, UPD_ADDR, '0));  // read
         exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, '0, '0));        // wait
         exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, UPD_ADDR, new_w)); // write
      end
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, '0, '0));           // done
   endtask

   task automatic compare();
      chk("ready", UPD_READY, cur.ready);
      chk("done",  UPD_DONE,  cur.done);
      chk("cs",    SRAM_CS,   cur.cs);
      chk("we",    SRAM_WE,   cur.we);
      if (cur.cs) chk("addr", SRAM_A, cur.a);
      if (cur.we) chk("wdata", SRAM_D, cur.d);
      if (!RST_N) begin
         chk("rst_addr",  SRAM_A, 0);
         chk("rst_wdata", SRAM_D, 0);
      end
      if (UPD_DONE) begin done_count++; done_cyc = cyc; end
      if (SRAM_CS) cs_count++;
      if (SRAM_CS && SRAM_WE) begin wr_count++; dut_wd = SRAM_D; end
      if (SRAM_CS && !SRAM_WE) dut_ra = SRAM_A;
   endtask

   // One clock: advance the model at the edge, then compare just after it.
   task automatic cycle();
      @(posedge CK);
      cyc++;
      m_accepted = 1'b0;
      if (!RST_N) begin
         exp_q.delete();
         cur = '0;
      end else begin
         if (cur.cs && cur.we) ref_mem[cur.a] = cur.d;
         if (exp_q.size() > 0)
            cur = exp_q.pop_front();
         else if (cur.ready && UPD_VALID) begin
            model_accept();
            cur = exp_q.pop_front();
         end else
            cur = mk(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      end
      #1;
      compare();
   endtask

   // ---------------- driver tasks ----------------
   task automatic send(input logic [AW-1:0] a, input logic [NS-1:0] m,
                       input logic dir, input logic [WW-1:0] st, output int lat);
      int budget;
      UPD_ADDR = a; UPD_MASK = m; UPD_DIR = dir; UPD_STEP = st; UPD_VALID = 1'b1;
      budget = 0;
      do begin cycle(); budget++; end while (!m_accepted && budget < 20);
      UPD_VALID = 1'b0;
      lat = -1;
      if (!m_accepted) begin
         chk("accept_timeout", 0, 1);
         return;
      end
      budget = 0;
      while (done_cyc < acc_cyc && budget < 10) begin cycle(); budget++; end
      if (done_cyc < acc_cyc) chk("done_timeout", 0, 1);
      else lat = done_cyc - acc_cyc + 1;   // DONE is the lat-th cycle after the accept edge
   endtask

   function automatic logic [DW-1:0] init_word(input int a);
      case (a)
         8'h05:   return 32'h76543210;
         8'h10:   return 32'hF000000F;
         8'h11:   return 32'h10000001;
         8'h20:   return 32'h11111111;
         8'h22:   return 32'h12345678;
         default: return {$urandom()};
      endcase
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      int lat, cs0, wr0, dn0, acc0;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

      #2 RST_N = 1'b0;
      #1;
      chk("async_rst_ready", UPD_READY, 0);
      chk("async_rst_cs",    SRAM_CS,   0);

      // Preload the SRAM while the block is held in reset.
      pre_en = 1'b1;
      for (int i = 0; i < 256; i++) begin
         pre_addr = i[AW-1:0];
         pre_data = ref_mem[i];
         cycle();
      end
      pre_en = 1'b0;
      chk("reset_done", UPD_DONE, 0);
      chk("reset_we",   SRAM_WE,  0);

      RST_N = 1'b1;
      cycle();
      chk("ready_after_reset", UPD_READY, 1);

      // Full increment of every synapse.
      send(8'h05, 8'hFF, 1'b1, 4'd1, lat);
      chk("inc_read_addr", dut_ra, 8'h05);
      chk("inc_wdata", dut_wd, 32'h87654321);
      chk("inc_latency", lat, 4);
      cycle();

      // Overflow at both end synapses.
      send(8'h10, 8'h81, 1'b1, 4'd2, lat);
`ifdef SYN_WEIGHT_SAT_EN
      chk("ovf_wdata", dut_wd, 32'hF000000F);
`else
      chk("ovf_wdata", dut_wd, 32'h10000001);
`endif

      // Underflow at both end synapses.
      send(8'h11, 8'h81, 1'b0, 4'd3, lat);
`ifdef SYN_WEIGHT_SAT_EN
      chk("unf_wdata", dut_wd, 32'h00000000);
`else
      chk("unf_wdata", dut_wd, 32'hE000000E);
`endif

      // Empty mask: no SRAM access, one-cycle latency.
      cycle();
      cs0 = cs_count;
      send(8'h30, 8'h00, 1'b1, 4'd7, lat);
      chk("nomask_latency", lat, 1);
      cycle();
      chk("nomask_ready_back", UPD_READY, 1);
      chk("nomask_no_cs", cs_count - cs0, 0);

      // Zero step still writes back unchanged.
      send(8'h20, 8'h0F, 1'b1, 4'd0, lat);
      chk("step0_wdata", dut_wd, 32'h11111111);
      chk("step0_latency", lat, 4);

      // Reset during WAIT aborts the request.
      UPD_ADDR = 8'h22; UPD_MASK = 8'hFF; UPD_DIR = 1'b1; UPD_STEP = 4'd5; UPD_VALID = 1'b1;
      for (int i = 0; i < 20 && !m_accepted; i++) cycle();
      chk("abort_accepted", m_accepted, 1);
      UPD_VALID = 1'b0;
      cycle();                                // now in WAIT
      chk("abort_in_wait_cs", SRAM_CS, 0);
      wr0 = wr_count; dn0 = done_count;
      RST_N = 1'b0;
      #1;
      chk("abort_async_ready", UPD_READY, 0);
      chk("abort_async_addr",  SRAM_A,    0);
      cycle();
      RST_N = 1'b1;
      for (int i = 0; i < 8; i++) cycle();
      chk("abort_no_write", wr_count - wr0, 0);
      chk("abort_no_done",  done_count - dn0, 0);
      chk("abort_mem_kept", mem[8'h22], 32'h12345678);

      // Valid held high with changing inputs.
      acc0 = m_acc_count; dn0 = done_count;
      UPD_VALID = 1'b1;
      for (int i = 0; i < 60; i++) begin
         UPD_ADDR = 8'h40 + 8'($urandom_range(0, 15));
         UPD_MASK = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
         UPD_DIR  = 1'($urandom_range(0, 1));
         UPD_STEP = 4'($urandom_range(0, 15));
         cycle();
      end
      UPD_VALID = 1'b0;
      for (int i = 0; i < 8; i++) cycle();
      chk("held_valid_accepts", done_count - dn0, m_acc_count - acc0);

      // Random valid and random requests.
      for (int i = 0; i < 400; i++) begin
         UPD_VALID = 1'($urandom_range(0, 1));
         UPD_ADDR  = 8'h40 + 8'($urandom_range(0, 15));
         UPD_MASK  = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
         UPD_DIR   = 1'($urandom_range(0, 1));
         UPD_STEP  = 4'($urandom_range(0, 15));
         cycle();
      end
      UPD_VALID = 1'b0;
      for (int i = 0; i < 8; i++) cycle();
      for (int a = 8'h40; a < 8'h50; a++) chk("final_mem", mem[a], ref_mem[a]);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/syn_weight_updater.md
SYN_WEIGHT_UPDATER -- requirements
Module: syn_weight_updater

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8: synaptic SRAM word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: synaptic SRAM word width.
REQ-003 SHALL have parameter WEIGHT_WIDTH, default 4: unsigned weight width; NSYN = DATA_WIDTH/WEIGHT_WIDTH synapses per word (8 by default), with synapse k in bits [k*WEIGHT_WIDTH +: WEIGHT_WIDTH].
REQ-004 SHALL have ports: CK  in  1  clock, all logic on rising edge.
REQ-005 RST_N  in  1  asynchronous active-low reset.
REQ-006 UPD_VALID  in  1  update request valid.
REQ-007 UPD_READY  out  1  block can accept a request.
REQ-008 UPD_ADDR  in  ADDR_WIDTH  target word address.
REQ-009 UPD_MASK  in  NSYN  per-synapse update enable.
REQ-010 UPD_DIR  in  1  1 = potentiate (add), 0 = depress (subtract).
REQ-011 UPD_STEP  in  WEIGHT_WIDTH  unsigned step magnitude.
REQ-012 UPD_DONE  out  1  one-cycle pulse per completed request.
REQ-013 SRAM_CS, SRAM_WE  out  1 each  synaptic SRAM chip select / write enable.
REQ-014 SRAM_A  out  ADDR_WIDTH; SRAM_D  out  DATA_WIDTH; SRAM_Q  in  DATA_WIDTH: SRAM address, write data, read data.

Function
REQ-015 SHALL implement FSM states IDLE, READ, WAIT, WRITE, DONE; all outputs registered.
REQ-016 IDLE: UPD_READY=1; on UPD_VALID&UPD_READY at a rising edge, latch ADDR/MASK/DIR/STEP; go READ if MASK!=0, else go DONE with no SRAM access.
REQ-017 READ (1 cycle): SRAM_CS=1, SRAM_WE=0, SRAM_A=latched address; go WAIT.
REQ-018 WAIT (1 cycle): SRAM_CS=0; SRAM_Q is valid (SRAM 1-cycle registered read); register updated word; go WRITE.
REQ-019 WRITE (1 cycle): SRAM_CS=1, SRAM_WE=1, SRAM_A=latched address, SRAM_D=updated word; go DONE.
REQ-020 DONE (1 cycle): UPD_DONE=1, UPD_READY=0, SRAM_CS=0; go IDLE.
REQ-021 UPD_READY SHALL be 0 in every state except IDLE; request inputs SHALL be ignored outside IDLE.
REQ-022 Accept-to-UPD_DONE latency SHALL be 4 cycles for MASK!=0, 1 cycle for MASK==0; throughput 1 request per 5 cycles (2 for MASK==0).
REQ-023 Masked-off synapses SHALL be written back unchanged bit-exact.
REQ-024 Unmasked synapse w: DIR=1 -> w+STEP, DIR=0 -> w-STEP, computed at WEIGHT_WIDTH+1 bits before limiting per REQ-030.
REQ-025 STEP=0 with MASK!=0 SHALL still perform the full read/write cycle, writing the word unchanged.
REQ-026 SRAM_WE SHALL never be 1 while SRAM_CS=0.

Reset
REQ-027 RST_N low SHALL asynchronously force state IDLE, UPD_READY=0, UPD_DONE=0, SRAM_CS=0, SRAM_WE=0, SRAM_A=0, SRAM_D=0, latched request=0.
REQ-028 UPD_READY SHALL become 1 on the first rising edge after RST_N deasserts.
REQ-029 Reset during READ/WAIT/WRITE SHALL abort the request: no further SRAM write, no UPD_DONE.

Configuration
REQ-030 Macro SYN_WEIGHT_SAT_EN defined: results clamp to [0, 2^WEIGHT_WIDTH-1]; undefined: results wrap modulo 2^WEIGHT_WIDTH.

Verification
REQ-031 Pre-load word 0x76543210 @0x05; request ADDR=0x05, MASK=0xFF, DIR=1, STEP=1 -> READ cycle CS=1 WE=0 A=0x05, WRITE cycle D=0x87654321, UPD_DONE 4 cycles after accept.
REQ-032 Word 0xF000000F, MASK=0x81, DIR=1, STEP=2 -> with SYN_WEIGHT_SAT_EN D=0xF000000F; without D=0x10000001.
REQ-033 Word 0x10000001, MASK=0x81, DIR=0, STEP=3 -> with macro D=0x00000000; without D=0xE000000E.
REQ-034 MASK=0x00 request -> no SRAM_CS assertion, UPD_DONE exactly 1 cycle after accept, UPD_READY back next cycle.
REQ-035 Word 0x11111111, MASK=0x0F, DIR=1, STEP=0 -> D=0x11111111 written; then RST_N pulsed low during WAIT of a second request -> no write, no UPD_DONE, SRAM word unchanged.
REQ-036 UPD_VALID held high continuously with varying inputs -> exactly one accept per UPD_READY cycle, inputs outside IDLE ignored.
